// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Fetch-side controller for the 32-bit instruction register of the LegV8
//   64-bit core. Holds the fetch PC, requests words from instruction memory
//   with a req/ready handshake and loads each returned word into the
//   instruction register exactly once, in order. Handles downstream stall,
//   branch/exception redirect and enable-based start/stop.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//     defined   - a request that waits TIMEOUT cycles for imem_ready sets the
//                 sticky fetch_error flag and parks the sequencer in IDLE
//                 until a redirect (or reset) clears it.
//     undefined - no timeout counter; fetch_error is tied low.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   enable       fetch run control
//   stall        downstream cannot accept an instruction this cycle
//   redirect     redirect pulse; redirect_pc is the new fetch address
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem_req     request valid (registered)
//   imem_addr    word-aligned request address (registered)
//   imem_ready   one-cycle response strobe, imem_rdata valid with it
//   imem_rdata   fetched instruction word
//   ir_load      one-cycle instruction register load strobe (registered)
//   ir_d         instruction for the instruction register (registered)
//   ir_pc        address of the instruction on ir_d (registered)
//   busy         high while not IDLE (registered)
//   fetch_error  sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned    AW       = 64,
   parameter int unsigned    IW       = 32,
   parameter logic [AW-1:0]  RESET_PC = '0,
   parameter int unsigned    TIMEOUT  = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          stall,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ready,
   input  logic [IW-1:0] imem_rdata,
   output logic          ir_load,
   output logic [IW-1:0] ir_d,
   output logic [AW-1:0] ir_pc,
   output logic          busy,
   output logic          fetch_error
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc, pc_nxt, pc_inc;
   logic [IW-1:0] hold_d, hold_d_nxt;
   logic          load_nxt;
   logic [IW-1:0] ir_d_nxt;
   logic [AW-1:0] ir_pc_nxt;
   logic          req_nxt;
   logic          busy_nxt;
   state_t        run_state;

   // The request address is the PC itself: the PC only moves when a word is
   // consumed or on redirect, so it always names the word being fetched.
   assign imem_addr = pc;
   assign pc_inc    = pc + AW'(4);
   assign run_state = enable ? FETCH : IDLE;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^redirect_pc[1:0];

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          err_nxt;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT;
   assign fetch_error    = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      hold_d_nxt = hold_d;
      load_nxt   = 1'b0;
      ir_d_nxt   = ir_d;
      ir_pc_nxt  = ir_pc;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_nxt = wait_cnt;
      err_nxt      = fetch_error;
`endif

      if (redirect) begin
         // Redirect discards any response this cycle and any held word.
         pc_nxt    = {redirect_pc[AW-1:2], 2'b00};
         state_nxt = run_state;
`ifdef FETCH_TIMEOUT_EN
         err_nxt      = 1'b0;
         wait_cnt_nxt = '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (enable && !fetch_error) state_nxt = FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt_nxt = '0;
`endif
                  if (!stall) begin
                     load_nxt  = 1'b1;
                     ir_d_nxt  = imem_rdata;
                     ir_pc_nxt = pc;
                     pc_nxt    = pc_inc;
                     state_nxt = run_state;
                  end else begin
                     hold_d_nxt = imem_rdata;
                     state_nxt  = HOLD;
                  end
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  err_nxt      = 1'b1;
                  state_nxt    = IDLE;
                  wait_cnt_nxt = '0;
               end else begin
                  wait_cnt_nxt = wait_cnt + CW'(1);
               end
`endif
            end
            HOLD: begin
               // The PC still names the held word until it is delivered.
               if (!stall) begin
                  load_nxt  = 1'b1;
                  ir_d_nxt  = hold_d;
                  ir_pc_nxt = pc;
                  pc_nxt    = pc_inc;
                  state_nxt = run_state;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

`ifdef FETCH_TIMEOUT_EN
      if (state_nxt != FETCH) wait_cnt_nxt = '0;
`endif

      req_nxt  = (state_nxt == FETCH);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         hold_d   <= '0;
         imem_req <= 1'b0;
         ir_load  <= 1'b0;
         ir_d     <= '0;
         ir_pc    <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         hold_d   <= hold_d_nxt;
         imem_req <= req_nxt;
         ir_load  <= load_nxt;
         ir_d     <= ir_d_nxt;
         ir_pc    <= ir_pc_nxt;
         busy     <= busy_nxt;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt    <= '0;
         fetch_error <= 1'b0;
      end else begin
         wait_cnt    <= wait_cnt_nxt;
         fetch_error <= err_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Scoreboard bench for fetch_sequencer. The stimulus side plays the memory
//   and downstream, and keeps a transaction-level model: the next address to
//   fetch, plus at most one accepted-but-undelivered word. Every word that
//   must reach the instruction register is pushed into a queue; a monitor
//   pops one entry per ir_load and checks ir_d/ir_pc, and checks that both
//   hold their last values otherwise.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int unsigned AW = 64;
   localparam int unsigned IW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic          stall;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready;
   logic [IW-1:0] imem_rdata;
   logic          ir_load;
   logic [IW-1:0] ir_d;
   logic [AW-1:0] ir_pc;
   logic          busy;
   logic          fetch_error;

   always #5 clock = ~clock;

   fetch_sequencer #(
      .AW       (AW),
      .IW       (IW),
      .RESET_PC ('0),
      .TIMEOUT  (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .ir_load     (ir_load),
      .ir_d        (ir_d),
      .ir_pc       (ir_pc),
      .busy        (busy),
      .fetch_error (fetch_error)
   );

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] d;
   } item_t;

   item_t         expq[$];
   int            total = 0;
   int            bad   = 0;

   logic [AW-1:0] m_pc;
   bit            held;
   item_t         held_it;
   logic [AW-1:0] last_pc;
   logic [IW-1:0] last_d;
   bit            mon_on   = 1'b0;
   bit            auto_chk = 1'b0;
   int            waitc    = 0;

   function automatic void chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: sample on the falling edge, away from the active edge.
   item_t mon_it;
   always @(negedge clock) begin
      if (mon_on) begin
         if (ir_load === 1'b1) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_load: got ir_pc=%h ir_d=%h want no load", ir_pc, ir_d);
            end else begin
               mon_it = expq.pop_front();
               chk("ir_pc", ir_pc, mon_it.pc);
               chk("ir_d", AW'(ir_d), AW'(mon_it.d));
               last_pc = mon_it.pc;
               last_d  = mon_it.d;
            end
         end else begin
            chk("ir_load_x", AW'(ir_load), '0);
            chk("hold_ir_pc", ir_pc, last_pc);
            chk("hold_ir_d", AW'(ir_d), AW'(last_d));
         end
      end
   end

   // One clock of stimulus, entered and left at negedge+1.
   task automatic step(input bit en, input bit stl, input bit rdr,
                       input logic [AW-1:0] rpc, input bit rdy);
      item_t it;
      enable      = en;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      imem_ready  = rdy && imem_req;
      imem_rdata  = $urandom;
      if (rdr) begin
         m_pc = {rpc[AW-1:2], 2'b00};
         held = 1'b0;
      end else if (held) begin
         if (!stl) begin
            expq.push_back(held_it);
            m_pc = m_pc + 64'd4;
            held = 1'b0;
         end
      end else if (imem_ready) begin
         it.pc = m_pc;
         it.d  = imem_rdata;
         if (!stl) begin
            expq.push_back(it);
            m_pc = m_pc + 64'd4;
         end else begin
            held    = 1'b1;
            held_it = it;
         end
      end
      @(negedge clock);
      #1;
      imem_ready = 1'b0;
      redirect   = 1'b0;
      if (auto_chk) begin
         chk("imem_req", AW'(imem_req), held ? '0 : AW'(1));
         if (imem_req) chk("imem_addr", imem_addr, m_pc);
         chk("busy", AW'(busy), AW'(1));
         chk("fetch_error", AW'(fetch_error), '0);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b1;
      stall      = 1'b0;
      redirect   = 1'b0;
      imem_ready = imem_req;
      imem_rdata = $urandom;
      expq.delete();
      held    = 1'b0;
      m_pc    = '0;
      last_pc = '0;
      last_d  = '0;
      mon_on  = 1'b1;
      @(negedge clock);
      #1;
      reset      = 1'b0;
      enable     = 1'b0;
      imem_ready = 1'b0;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_req"}, AW'(imem_req), '0);
      chk({tag, "_addr"}, imem_addr, '0);
      chk({tag, "_busy"}, AW'(busy), '0);
      chk({tag, "_err"}, AW'(fetch_error), '0);
      chk({tag, "_ir_load"}, AW'(ir_load), '0);
      chk({tag, "_ir_d"}, AW'(ir_d), '0);
      chk({tag, "_ir_pc"}, ir_pc, '0);
   endtask

   initial begin
      bit            rdr, stl, rdy;
      logic [AW-1:0] rpc;

      reset       = 1'b1;
      enable      = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ready  = 1'b0;
      imem_rdata  = '0;
      @(negedge clock);
      #1;
      do_reset();
      chk_reset_state("reset");

      // Idle stays idle with enable low, even if memory strobes ready.
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("idle_req", AW'(imem_req), '0);
      chk("idle_busy", AW'(busy), '0);

      // Start fetch: request at the reset PC one cycle later.
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("start_req", AW'(imem_req), AW'(1));
      chk("start_addr", imem_addr, '0);
      auto_chk = 1'b1;

      // Back-to-back responses 0,4,8,C.
      for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Response at 0x10 with stall held for 3 cycles, then released.
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("after_hold_addr", imem_addr, 64'h14);

      // Redirect to 0x203 together with the response for 0x40.
      step(1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
      step(1'b1, 1'b0, 1'b1, 64'h203, 1'b1);
      chk("redir_addr", imem_addr, 64'h200);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Redirect while holding the word for 0x80.
      step(1'b1, 1'b0, 1'b1, 64'h80, 1'b0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 64'h300, 1'b0);
      chk("hold_redir_addr", imem_addr, 64'h300);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Randomized traffic with enable held high.
      for (int unsigned i = 0; i < 800; i++) begin
         rdr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0)
            rpc = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | 32'($urandom_range(0, 31))};
         else
            rpc = {$urandom, $urandom};
         stl = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 2) != 0) || (waitc >= 6);
         if (imem_req && !rdy && !rdr) waitc++;
         else waitc = 0;
         step(1'b1, stl, rdr, rpc, rdy);
      end
      step(1'b1, 1'b1, 1'b1, 64'h0, 1'b0);
      auto_chk = 1'b0;

      // Enable drop with a request outstanding, across the PC wrap point.
      step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("outstanding_req", AW'(imem_req), AW'(1));
      chk("outstanding_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("stop_req", AW'(imem_req), '0);
      chk("stop_busy", AW'(busy), '0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("stopped_req", AW'(imem_req), '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("wrap_req", AW'(imem_req), AW'(1));
      chk("wrap_addr", imem_addr, '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      chk("wrap_next_addr", imem_addr, 64'h4);

`ifdef FETCH_TIMEOUT_EN
      // Memory never answers: error after 16 request cycles.
      step(1'b1, 1'b0, 1'b1, 64'h100, 1'b0);
      chk("to_req", AW'(imem_req), AW'(1));
      for (int unsigned i = 0; i < 15; i++) begin
         step(1'b1, 1'b0, 1'b0, '0, 1'b0);
         chk("to_wait_err", AW'(fetch_error), '0);
         chk("to_wait_req", AW'(imem_req), AW'(1));
      end
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("to_err", AW'(fetch_error), AW'(1));
      chk("to_err_req", AW'(imem_req), '0);
      chk("to_err_busy", AW'(busy), '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("to_parked_err", AW'(fetch_error), AW'(1));
      chk("to_parked_req", AW'(imem_req), '0);
      step(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
      chk("to_clear_err", AW'(fetch_error), '0);
      chk("to_restart_req", AW'(imem_req), AW'(1));
      chk("to_restart_addr", imem_addr, '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
`endif

      // Reset while a request is pending and memory answers in that cycle.
      chk("pre_reset_req", AW'(imem_req), AW'(1));
      do_reset();
      chk_reset_state("midreq_reset");
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("post_reset_req", AW'(imem_req), '0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);

      chk("leftover_words", AW'(expq.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
